// File: rtl/sdram_client_arbiter_if.sv
// rtl/sdram_client_arbiter_if.sv - client and controller signal bundle for the SDRAM client arbiter
interface sdram_client_arbiter_if;
    logic [26:1] sdr_cpu_addr;
    logic [15:0] sdr_cpu_data;
    logic [1:0]  sdr_cpu_be;
    logic        sdr_cpu_rw;
    logic        sdr_cpu_req;
    logic [15:0] sdr_cpu_q;
    logic        sdr_cpu_ack;

    logic [26:1] sdr_scn_main_addr;
    logic        sdr_scn_main_req;
    logic [31:0] sdr_scn_main_q;
    logic        sdr_scn_main_ack;

    logic [26:1] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_be;
    logic        ram_we;
    logic        ram_req;
    logic [15:0] ram_dout;
    logic        ram_ready;

    // Arbiter side.
    modport slave (
        input  sdr_cpu_addr, sdr_cpu_data, sdr_cpu_be, sdr_cpu_rw, sdr_cpu_req,
        input  sdr_scn_main_addr, sdr_scn_main_req,
        input  ram_dout, ram_ready,
        output sdr_cpu_q, sdr_cpu_ack, sdr_scn_main_q, sdr_scn_main_ack,
        output ram_addr, ram_din, ram_be, ram_we, ram_req
    );

    // Client and controller side.
    modport master (
        output sdr_cpu_addr, sdr_cpu_data, sdr_cpu_be, sdr_cpu_rw, sdr_cpu_req,
        output sdr_scn_main_addr, sdr_scn_main_req,
        output ram_dout, ram_ready,
        input  sdr_cpu_q, sdr_cpu_ack, sdr_scn_main_q, sdr_scn_main_ack,
        input  ram_addr, ram_din, ram_be, ram_we, ram_req
    );
endinterface

// File: rtl/sdram_client_arbiter.sv
// rtl/sdram_client_arbiter.sv - round-robin CPU/SCN toggle-handshake arbiter onto a single-port SDRAM controller
module sdram_client_arbiter #(
    parameter logic [26:1] SCN_BASE = 26'h0100000
) (
    input  logic                   clk,
    input  logic                   reset,
    sdram_client_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CPU_WAIT, SCN_LO_WAIT, SCN_HI_WAIT} state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_SCN = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [26:1] ram_addr_q, ram_addr_d;
    logic [15:0] ram_din_q, ram_din_d;
    logic [1:0]  ram_be_q, ram_be_d;
    logic        ram_we_q, ram_we_d;
    logic        ram_req_q, ram_req_d;
    logic [15:0] cpu_q_q, cpu_q_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [31:0] scn_q_q, scn_q_d;
    logic        scn_ack_q, scn_ack_d;

    logic        cpu_pend, scn_pend;
    logic [26:1] scn_lo_addr;

    assign cpu_pend = bus.sdr_cpu_req != cpu_ack_q;
    assign scn_pend = bus.sdr_scn_main_req != scn_ack_q;
    // A 32-bit fetch always starts on the even word; the base add wraps modulo 2^26.
    assign scn_lo_addr = (bus.sdr_scn_main_addr & ~26'h1) + SCN_BASE;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_be_d     = ram_be_q;
        ram_we_d     = ram_we_q;
        ram_req_d    = 1'b0;
        cpu_q_d      = cpu_q_q;
        cpu_ack_d    = cpu_ack_q;
        scn_q_d      = scn_q_q;
        scn_ack_d    = scn_ack_q;
        case (state_q)
            IDLE: begin
                if (cpu_pend && (!scn_pend || last_grant_q == GRANT_SCN)) begin
                    last_grant_d = GRANT_CPU;
                    ram_req_d    = 1'b1;
                    ram_addr_d   = bus.sdr_cpu_addr;
                    ram_din_d    = bus.sdr_cpu_data;
                    ram_be_d     = bus.sdr_cpu_be;
                    ram_we_d     = ~bus.sdr_cpu_rw;
                    state_d      = CPU_WAIT;
                end else if (scn_pend) begin
                    last_grant_d = GRANT_SCN;
                    ram_req_d    = 1'b1;
                    ram_addr_d   = scn_lo_addr;
                    ram_we_d     = 1'b0;
                    ram_be_d     = 2'b11;
                    state_d      = SCN_LO_WAIT;
                end
            end
            CPU_WAIT: begin
                if (bus.ram_ready) begin
                    if (!ram_we_q) begin
                        cpu_q_d = bus.ram_dout;
                    end
                    cpu_ack_d = ~cpu_ack_q;
                    state_d   = IDLE;
                end
            end
            SCN_LO_WAIT: begin
                // Chain the upper half immediately so the fetch holds the controller.
                if (bus.ram_ready) begin
                    scn_q_d[15:0] = bus.ram_dout;
                    ram_req_d     = 1'b1;
                    ram_addr_d    = ram_addr_q + 26'd1;
                    state_d       = SCN_HI_WAIT;
                end
            end
            SCN_HI_WAIT: begin
                if (bus.ram_ready) begin
                    scn_q_d[31:16] = bus.ram_dout;
                    scn_ack_d      = ~scn_ack_q;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_CPU;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_be_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_req_q    <= 1'b0;
            cpu_q_q      <= '0;
            cpu_ack_q    <= 1'b0;
            scn_q_q      <= '0;
            scn_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_be_q     <= ram_be_d;
            ram_we_q     <= ram_we_d;
            ram_req_q    <= ram_req_d;
            cpu_q_q      <= cpu_q_d;
            cpu_ack_q    <= cpu_ack_d;
            scn_q_q      <= scn_q_d;
            scn_ack_q    <= scn_ack_d;
        end
    end

    assign bus.ram_addr         = ram_addr_q;
    assign bus.ram_din          = ram_din_q;
    assign bus.ram_be           = ram_be_q;
    assign bus.ram_we           = ram_we_q;
    assign bus.ram_req          = ram_req_q;
    assign bus.sdr_cpu_q        = cpu_q_q;
    assign bus.sdr_cpu_ack      = cpu_ack_q;
    assign bus.sdr_scn_main_q   = scn_q_q;
    assign bus.sdr_scn_main_ack = scn_ack_q;
endmodule

// File: tb/tb_sdram_client_arbiter.sv
// tb/tb_sdram_client_arbiter.sv - randomized self-checking bench for sdram_client_arbiter
module tb_sdram_client_arbiter;
    localparam logic [26:1] SCN_BASE = 26'h0100000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_client_arbiter_if bus();
    sdram_client_arbiter #(.SCN_BASE(SCN_BASE)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: client-visible results plus the round-robin memory.
    logic        exp_cpu_ack, exp_scn_ack;
    logic [15:0] exp_cpu_q;
    logic [31:0] exp_scn_q;
    logic        model_last_scn;
    logic [26:1] c_addr, s_addr;
    logic [15:0] c_data;
    logic [1:0]  c_be;
    logic        c_rw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (bus.ram_req !== 1'b1 && cyc < 32) begin
            @(negedge clk);
            cyc++;
        end
        check("ram_req_seen", bus.ram_req, 1);
    endtask

    task automatic serve(input string tag, input logic [26:1] a, input logic we, input logic [1:0] be,
                         input logic [15:0] din, input logic [15:0] dout, input int lat_in,
                         input int scramble, output int cyc);
        int lat;
        wait_req(cyc);
        check({tag, "_addr"}, bus.ram_addr, a);
        check({tag, "_we"}, bus.ram_we, we);
        check({tag, "_be"}, bus.ram_be, be);
        if (we) check({tag, "_din"}, bus.ram_din, din);
        if (scramble == 1) begin
            bus.sdr_cpu_addr = 26'($urandom);
            bus.sdr_cpu_data = 16'($urandom);
            bus.sdr_cpu_be   = 2'($urandom);
            bus.sdr_cpu_rw   = 1'($urandom);
        end else if (scramble == 2) begin
            bus.sdr_scn_main_addr = 26'($urandom);
        end
        lat = (lat_in > 0) ? lat_in : int'($urandom_range(1, 4));
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_req_single"}, bus.ram_req, 0);
            check({tag, "_addr_hold"}, bus.ram_addr, a);
            check({tag, "_we_hold"}, bus.ram_we, we);
        end
        bus.ram_dout  = dout;
        bus.ram_ready = 1'b1;
        @(negedge clk);
        bus.ram_ready = 1'b0;
        bus.ram_dout  = 16'($urandom);
    endtask

    task automatic cpu_issue(input logic [26:1] a, input logic [15:0] d, input logic [1:0] be, input logic rw);
        c_addr = a; c_data = d; c_be = be; c_rw = rw;
        bus.sdr_cpu_addr = a;
        bus.sdr_cpu_data = d;
        bus.sdr_cpu_be   = be;
        bus.sdr_cpu_rw   = rw;
        bus.sdr_cpu_req  = ~bus.sdr_cpu_req;
    endtask

    task automatic scn_issue(input logic [26:1] a);
        s_addr = a;
        bus.sdr_scn_main_addr = a;
        bus.sdr_scn_main_req  = ~bus.sdr_scn_main_req;
    endtask

    task automatic cpu_serve(input logic [15:0] dout, input int lat, output int cyc);
        serve("cpu", c_addr, ~c_rw, c_be, c_data, dout, lat, 1, cyc);
        exp_cpu_ack = ~exp_cpu_ack;
        if (c_rw) exp_cpu_q = dout;
        model_last_scn = 1'b0;
        check("cpu_ack", bus.sdr_cpu_ack, exp_cpu_ack);
        check("cpu_q", bus.sdr_cpu_q, exp_cpu_q);
    endtask

    task automatic scn_serve(input logic [15:0] lo, input logic [15:0] hi, output int cyc);
        logic [26:1] base;
        int c2;
        base = (s_addr & ~26'h1) + SCN_BASE;
        serve("scn_lo", base, 1'b0, 2'b11, 16'h0, lo, 0, 2, cyc);
        check("scn_ack_after_lo", bus.sdr_scn_main_ack, exp_scn_ack);
        serve("scn_hi", base + 26'd1, 1'b0, 2'b11, 16'h0, hi, 0, 0, c2);
        check("scn_hi_chained", c2, 0);
        exp_scn_ack = ~exp_scn_ack;
        exp_scn_q   = {hi, lo};
        model_last_scn = 1'b1;
        check("scn_ack", bus.sdr_scn_main_ack, exp_scn_ack);
        check("scn_q", bus.sdr_scn_main_q, exp_scn_q);
    endtask

    task automatic contest();
        int cyc;
        logic scn_first;
        scn_first = ~model_last_scn;
        bus.sdr_cpu_addr = 26'($urandom);
        cpu_issue(26'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
        scn_issue(26'($urandom));
        if (scn_first) begin
            scn_serve(16'($urandom), 16'($urandom), cyc);
            check("contest_first_lat", cyc, 1);
            cpu_serve(16'($urandom), 0, cyc);
            check("contest_second_lat", cyc, 1);
        end else begin
            cpu_serve(16'($urandom), 0, cyc);
            check("contest_first_lat", cyc, 1);
            scn_serve(16'($urandom), 16'($urandom), cyc);
            check("contest_second_lat", cyc, 1);
        end
    endtask

    task automatic model_reset();
        exp_cpu_ack = 0; exp_scn_ack = 0; exp_cpu_q = 0; exp_scn_q = 0;
        model_last_scn = 1'b0;
        bus.sdr_cpu_req = 0; bus.sdr_scn_main_req = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_req"}, bus.ram_req, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_ram_din"}, bus.ram_din, 0);
        check({tag, "_ram_be"}, bus.ram_be, 0);
        check({tag, "_ram_we"}, bus.ram_we, 0);
        check({tag, "_cpu_q"}, bus.sdr_cpu_q, 0);
        check({tag, "_cpu_ack"}, bus.sdr_cpu_ack, 0);
        check({tag, "_scn_q"}, bus.sdr_scn_main_q, 0);
        check({tag, "_scn_ack"}, bus.sdr_scn_main_ack, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, c2;
        reset = 1'b1;
        bus.sdr_cpu_addr = 0; bus.sdr_cpu_data = 0; bus.sdr_cpu_be = 0; bus.sdr_cpu_rw = 1;
        bus.sdr_scn_main_addr = 0; bus.ram_dout = 0; bus.ram_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Contention straight out of reset: SCN first, and again on the re-toggle.
        contest();
        contest();

        cpu_issue(26'h0000123, 16'h0000, 2'b11, 1'b1);
        cpu_serve(16'hBEEF, 3, cyc);
        check("cpu_read_lat", cyc, 1);
        check("cpu_read_q", bus.sdr_cpu_q, 16'hBEEF);
        check("cpu_read_ack", bus.sdr_cpu_ack, 1);

        cpu_issue(26'h0000200, 16'h00A5, 2'b01, 1'b0);
        cpu_serve(16'h5A5A, 0, cyc);
        check("cpu_write_q_held", bus.sdr_cpu_q, 16'hBEEF);

        scn_issue(26'h0000042);
        scn_serve(16'h1111, 16'h2222, cyc);
        check("scn_fetch_q", bus.sdr_scn_main_q, 32'h22221111);

        // Back-to-back CPU: next ram_req two cycles after the ready pulse.
        cpu_issue(26'($urandom), 16'($urandom), 2'b11, 1'b1);
        cpu_serve(16'($urandom), 0, cyc);
        cpu_issue(26'($urandom), 16'($urandom), 2'b10, 1'b0);
        cpu_serve(16'($urandom), 0, c2);
        check("b2b_cpu_lat", c2, 1);

        // Stray ready while idle must not disturb anything.
        bus.ram_dout = 16'hDEAD; bus.ram_ready = 1'b1;
        @(negedge clk);
        bus.ram_ready = 1'b0;
        @(negedge clk);
        check("idle_ready_cpu_ack", bus.sdr_cpu_ack, exp_cpu_ack);
        check("idle_ready_scn_ack", bus.sdr_scn_main_ack, exp_scn_ack);
        check("idle_ready_cpu_q", bus.sdr_cpu_q, exp_cpu_q);
        check("idle_ready_req", bus.ram_req, 0);

        // Base offset wrapping past 2^26.
        scn_issue(26'h3FFFFFF);
        scn_serve(16'($urandom), 16'($urandom), cyc);

        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (kind == 0) begin
                cpu_issue(26'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
                cpu_serve(16'($urandom), 0, cyc);
                check("rand_cpu_lat", cyc, 1);
            end else if (kind == 1) begin
                scn_issue(26'($urandom));
                scn_serve(16'($urandom), 16'($urandom), cyc);
                check("rand_scn_lat", cyc, 1);
            end else begin
                contest();
            end
        end

        // Reset while the upper SCN half is outstanding.
        scn_issue(26'($urandom));
        serve("rst_lo", (s_addr & ~26'h1) + SCN_BASE, 1'b0, 2'b11, 16'h0, 16'h1234, 0, 0, cyc);
        check("rst_in_hi_req", bus.ram_req, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_no_req", bus.ram_req, 0);
        end
        contest();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_client_arbiter.md
Name: sdram_client_arbiter

Overview:
- Sits downstream of the F2 core, between its two SDRAM client ports and the single-port SDRAM controller.
- Client ports: CPU ROM/work RAM (16-bit, read/write) and TC0100SCN tile ROM fetch (32-bit, read only).
- Converts each client's toggle req/ack handshake into single-cycle request pulses for the controller.
- Serialises the clients with round-robin arbitration. Splits each 32-bit SCN fetch into two 16-bit controller reads and reassembles the result.

Parameters:
SCN_BASE, 26'h0100000, word offset added to sdr_scn_main_addr before it reaches the controller (places tile ROM in SDRAM).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sdr_cpu_addr  in  26 [26:1]  CPU word address
sdr_cpu_data  in  16  CPU write data
sdr_cpu_be  in  2  CPU byte enables, [1]=upper
sdr_cpu_rw  in  1  1=read, 0=write
sdr_cpu_req  in  1  CPU request toggle
sdr_cpu_q  out  16  CPU read data
sdr_cpu_ack  out  1  CPU ack toggle
sdr_scn_main_addr  in  26 [26:1]  SCN word address
sdr_scn_main_req  in  1  SCN request toggle
sdr_scn_main_q  out  32  SCN read data
sdr_scn_main_ack  out  1  SCN ack toggle
ram_addr  out  26 [26:1]  controller word address
ram_din  out  16  controller write data
ram_be  out  2  controller byte enables
ram_we  out  1  1=write
ram_req  out  1  one-cycle start pulse
ram_dout  in  16  controller read data, valid when ram_ready=1
ram_ready  in  1  one-cycle completion pulse

Behaviour:
- Reset state (asynchronous): all outputs 0; state=IDLE; last_grant=CPU, so SCN wins the first contest.
- Pending conditions:
  - cpu_pend = sdr_cpu_req != sdr_cpu_ack
  - scn_pend = sdr_scn_main_req != sdr_scn_main_ack
- States: IDLE, CPU_WAIT, SCN_LO_WAIT, SCN_HI_WAIT.
- IDLE, one client pending: grant it.
- IDLE, both pending: grant the client that is not last_grant. Update last_grant on every grant.
- IDLE, none pending: stay; ram_req=0.
- CPU grant, next edge:
  - ram_req=1 for one cycle.
  - ram_addr=sdr_cpu_addr, ram_din=sdr_cpu_data, ram_be=sdr_cpu_be, ram_we=~sdr_cpu_rw.
  - state=CPU_WAIT.
- SCN grant, next edge:
  - ram_req=1; ram_addr={sdr_scn_main_addr[26:2],1'b0}+SCN_BASE.
  - ram_we=0, ram_be=2'b11.
  - state=SCN_LO_WAIT.
- CPU_WAIT on ram_ready:
  - If read, sdr_cpu_q<=ram_dout; on a write, sdr_cpu_q holds its value.
  - sdr_cpu_ack toggles on the same edge; state=IDLE.
- SCN_LO_WAIT on ram_ready:
  - sdr_scn_main_q[15:0]<=ram_dout.
  - Same edge: ram_req=1, ram_addr=previous+1; state=SCN_HI_WAIT.
- SCN_HI_WAIT on ram_ready:
  - sdr_scn_main_q[31:16]<=ram_dout; sdr_scn_main_ack toggles; state=IDLE.
  - Bits [31:16] update on the same edge as the ack, so the full 32-bit word is valid when the ack is visible.
- Request fields are captured only at the grant edge. Client inputs may change after the grant without effect.
- ram_addr/ram_din/ram_be/ram_we hold stable from the ram_req pulse until the matching ram_ready.
- ram_ready in IDLE is ignored.
- The controller never asserts ram_ready in the same cycle as ram_req.
- At most one controller transaction is outstanding; ram_req is never pulsed while a WAIT state is active.
- Minimum latency from request toggle to ram_req: 1 cycle after the toggle is sampled in IDLE.
- From ram_ready to the next grant's ram_req: 2 cycles (IDLE re-evaluates, then issues).
- Address arithmetic is 26-bit, modulo 2^26; SCN_BASE+addr wraps silently.
- A client re-toggling req while already pending is a protocol violation; behaviour is undefined.
- Reset mid-transaction: immediate return to IDLE with outputs cleared. The controller and clients share this reset, so no stale ram_ready is expected.

Test Plan:
- CPU read: addr=26'h0000123, rw=1, req toggle 0->1; ram_dout=16'hBEEF with ram_ready 3 cycles after ram_req -> one ram_req pulse, ram_we=0, ram_addr=0000123; sdr_cpu_q=BEEF; sdr_cpu_ack=1.
- CPU write: be=2'b01, data=16'h00A5, rw=0 -> ram_we=1, ram_be=01, ram_din=00A5; ack toggles; sdr_cpu_q unchanged.
- SCN fetch: addr=26'h0000042 -> two ram_req pulses with ram_addr=0100042 then 0100043; dout 1111 then 2222 -> sdr_scn_main_q=32'h22221111; ack toggles once, after the second ram_ready.
- Contention: both reqs toggle in the same cycle after reset -> SCN served first, then CPU. Re-toggle both -> SCN first again, because last_grant returns to CPU after the previous CPU service. Check last_grant alternates on each contest.
- Reset asserted in SCN_HI_WAIT -> all outputs 0 asynchronously, state IDLE. After release with no pending requests -> no ram_req.
- Back-to-back CPU: CPU re-toggles the cycle after its ack -> second ram_req exactly 2 cycles after the first ram_ready; no duplicate pulses.
